// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared defaults, derived widths and state type for the binarized FC popcount/activation stage
package fc_pkg;

  localparam int DIM_IN_DEF  = 110;
  localparam int DIM_OUT_DEF = 4;
  localparam int FOLD_DEF    = 2;

  function automatic int calc_cnt_w(input int dim_in);
    return $clog2(dim_in + 1);
  endfunction

  function automatic int calc_slice(input int dim_out, input int fold);
    return dim_out / fold;
  endfunction

  function automatic int calc_fw(input int fold);
    return (fold > 1) ? $clog2(fold) : 1;
  endfunction

  localparam int CNT_W_DEF = calc_cnt_w(DIM_IN_DEF);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/fc_popcount.sv
// rtl/fc_popcount.sv - combinational popcount of one neuron's XNOR products
module fc_popcount #(
  parameter int DIM_IN = 110,
  parameter int CNT_W  = $clog2(DIM_IN + 1)
) (
  input  logic [DIM_IN-1:0] bits,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DIM_IN; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/fc_popcount_act.sv
// rtl/fc_popcount_act.sv - folded popcount, threshold and activation packing for the binarized FC layer
// FC_RAW_SUM_EN adds sum_out, the registered raw popcount per neuron.
module fc_popcount_act
  import fc_pkg::*;
#(
  parameter  int DIM_IN  = DIM_IN_DEF,
  parameter  int DIM_OUT = DIM_OUT_DEF,
  parameter  int FOLD    = FOLD_DEF,
  localparam int SLICE   = calc_slice(DIM_OUT, FOLD),
  localparam int CNT_W   = calc_cnt_w(DIM_IN),
  localparam int FW      = calc_fw(FOLD)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SLICE-1:0][DIM_IN-1:0]     mult_out,
  input  logic [SLICE-1:0][CNT_W-1:0]      thresh,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DIM_OUT-1:0]               act_out,
`ifdef FC_RAW_SUM_EN
  output logic [DIM_OUT-1:0][CNT_W-1:0]    sum_out,
`endif
  output logic [FW-1:0]                    fold_idx
);

  state_e                         state_q, state_d;
  logic [FW-1:0]                  fold_q, fold_d;
  logic [DIM_OUT-1:0]             act_q, act_d;
  logic [SLICE-1:0][CNT_W-1:0]    pc;
`ifdef FC_RAW_SUM_EN
  logic [DIM_OUT-1:0][CNT_W-1:0]  sum_q, sum_d;
`endif

  for (genvar s = 0; s < SLICE; s++) begin : g_pc
    fc_popcount #(
      .DIM_IN (DIM_IN),
      .CNT_W  (CNT_W)
    ) u_popcount (
      .bits  (mult_out[s]),
      .count (pc[s])
    );
  end

  always_comb begin
    state_d = state_q;
    fold_d  = fold_q;
    act_d   = act_q;
`ifdef FC_RAW_SUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          // Only the lanes of the current fold slice are written; the rest hold.
          for (int j = 0; j < DIM_OUT; j++) begin
            if (FW'(j / SLICE) == fold_q) begin
              act_d[j] = (pc[j % SLICE] >= thresh[j % SLICE]);
`ifdef FC_RAW_SUM_EN
              sum_d[j] = pc[j % SLICE];
`endif
            end
          end
          if (fold_q == FW'(FOLD - 1)) begin
            fold_d  = '0;
            state_d = DONE;
          end else begin
            fold_d = fold_q + FW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      fold_q  <= '0;
      act_q   <= '0;
`ifdef FC_RAW_SUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      fold_q  <= fold_d;
      act_q   <= act_d;
`ifdef FC_RAW_SUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign act_out   = act_q;
  assign fold_idx  = fold_q;
`ifdef FC_RAW_SUM_EN
  assign sum_out   = sum_q;
`endif

endmodule

// File: tb/tb_fc_popcount_act.sv
// tb/tb_fc_popcount_act.sv - directed table-driven bench for fc_popcount_act (FOLD=2 and FOLD=1 instances)
`define CHK(nm, a, e) check(nm, 128'(a), 128'(e))
module tb_fc_popcount_act;

  logic                 clk = 1'b0;
  logic                 rst;

  logic                 in_valid, in_ready, out_valid, out_ready;
  logic [1:0][109:0]    mult_out;
  logic [1:0][6:0]      thresh;
  logic [3:0]           act_out;
  logic [0:0]           fold_idx;
  logic [3:0][6:0]      sum_out;

  logic                 in_valid1, in_ready1, out_valid1, out_ready1;
  logic [1:0][109:0]    mult1;
  logic [1:0][6:0]      thresh1;
  logic [1:0]           act1;
  logic [0:0]           fold1;
  logic [1:0][6:0]      sum1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fc_popcount_act #(.DIM_IN(110), .DIM_OUT(4), .FOLD(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mult_out  (mult_out),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .act_out   (act_out),
`ifdef FC_RAW_SUM_EN
    .sum_out   (sum_out),
`endif
    .fold_idx  (fold_idx)
  );

  fc_popcount_act #(.DIM_IN(110), .DIM_OUT(2), .FOLD(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .mult_out  (mult1),
    .thresh    (thresh1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .act_out   (act1),
`ifdef FC_RAW_SUM_EN
    .sum_out   (sum1),
`endif
    .fold_idx  (fold1)
  );

`ifndef FC_RAW_SUM_EN
  assign sum_out = '0;
  assign sum1    = '0;
`endif

  typedef struct {
    int         pc[4];
    int         th[4];
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    int         pc[2];
    int         th[2];
    logic [1:0] exp;
  } vec1_t;

  vec_t  vecs[5];
  vec1_t vecs1[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [109:0] ones(input int n, input int r);
    logic [109:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[(i + r) % 110] = 1'b1;
    return v;
  endfunction

  task automatic beat(input int p0, input int p1, input int t0, input int t1);
    mult_out = {ones(p1, 17), ones(p0, 3)};
    thresh   = {7'(t1), 7'(t0)};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mult_out = 'x;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    `CHK("release_out_valid", out_valid, 1'b0);
    `CHK("release_in_ready", in_ready, 1'b1);
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    logic [3:0][6:0] es;
    beat(v.pc[0], v.pc[1], v.th[0], v.th[1]);
    `CHK({tag, "_fold_mid"}, fold_idx, 1'b1);
    `CHK({tag, "_valid_mid"}, out_valid, 1'b0);
    beat(v.pc[2], v.pc[3], v.th[2], v.th[3]);
    `CHK({tag, "_valid"}, out_valid, 1'b1);
    `CHK({tag, "_in_ready"}, in_ready, 1'b0);
    `CHK({tag, "_fold_wrap"}, fold_idx, 1'b0);
    `CHK({tag, "_act"}, act_out, v.exp);
`ifdef FC_RAW_SUM_EN
    for (int i = 0; i < 4; i++) es[i] = 7'(v.pc[i]);
    `CHK({tag, "_sum"}, sum_out, es);
`else
    es = '0;
`endif
  endtask

  initial begin
    vecs[0] = '{pc: '{110, 110, 0, 0},   th: '{55, 55, 55, 55},  exp: 4'b0011};
    vecs[1] = '{pc: '{55, 55, 55, 55},   th: '{55, 56, 0, 111},  exp: 4'b0101};
    vecs[2] = '{pc: '{0, 110, 1, 109},   th: '{0, 111, 1, 109},  exp: 4'b1101};
    vecs[3] = '{pc: '{54, 56, 110, 100}, th: '{55, 55, 110, 101}, exp: 4'b0110};
    vecs[4] = '{pc: '{1, 0, 109, 110},   th: '{2, 1, 0, 110},    exp: 4'b1100};

    vecs1[0] = '{pc: '{10, 9},   th: '{10, 10},  exp: 2'b01};
    vecs1[1] = '{pc: '{0, 110},  th: '{0, 111},  exp: 2'b01};
    vecs1[2] = '{pc: '{110, 56}, th: '{110, 55}, exp: 2'b11};
    vecs1[3] = '{pc: '{54, 0},   th: '{55, 1},   exp: 2'b00};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; mult_out = '0; thresh = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; mult1 = '0; thresh1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    `CHK("reset_in_ready", in_ready, 1'b1);
    `CHK("reset_out_valid", out_valid, 1'b0);
    `CHK("reset_fold", fold_idx, 1'b0);
    `CHK("reset_act", act_out, 4'b0000);
`ifdef FC_RAW_SUM_EN
    `CHK("reset_sum", sum_out, 28'h0);
`endif

    for (int k = 0; k < 5; k++) begin
      run_vector(vecs[k], $sformatf("vec%0d", k));
      release_out();
    end

    run_vector(vecs[3], "bp");
    in_valid = 1'b1;
    mult_out = {ones(110, 0), ones(110, 0)};
    thresh   = {7'd0, 7'd0};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      `CHK($sformatf("bp_in_ready_%0d", c), in_ready, 1'b0);
      `CHK($sformatf("bp_act_%0d", c), act_out, 4'b0110);
      `CHK($sformatf("bp_fold_%0d", c), fold_idx, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    `CHK("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    `CHK("bp_first_beat_fold", fold_idx, 1'b1);

    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      `CHK($sformatf("gap_fold_%0d", c), fold_idx, 1'b1);
      `CHK($sformatf("gap_valid_%0d", c), out_valid, 1'b0);
    end
    beat(0, 0, 1, 0);
    `CHK("gap_valid", out_valid, 1'b1);
    `CHK("gap_act", act_out, 4'b1011);
    release_out();

    beat(110, 110, 0, 0);
    `CHK("rmid_fold_pre", fold_idx, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    `CHK("rmid_fold", fold_idx, 1'b0);
    `CHK("rmid_act", act_out, 4'b0000);
    `CHK("rmid_valid", out_valid, 1'b0);
    run_vector(vecs[1], "rmid_after");

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    `CHK("rdone_valid", out_valid, 1'b0);
    `CHK("rdone_act", act_out, 4'b0000);
    `CHK("rdone_in_ready", in_ready, 1'b1);

    in_valid1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mult1   = {ones(vecs1[k].pc[1], 40), ones(vecs1[k].pc[0], 5)};
      thresh1 = {7'(vecs1[k].th[1]), 7'(vecs1[k].th[0])};
      n_total++;
      if (in_ready1 === 1'b1) n_pass++;
      else $display("FAIL f1_in_ready_hi_%0d: got %0h", k, in_ready1);
      @(posedge clk); #1;
      n_total++;
      if (in_ready1 === 1'b0) n_pass++;
      else $display("FAIL f1_in_ready_lo_%0d: got %0h", k, in_ready1);
      n_total++;
      if (out_valid1 === 1'b1) n_pass++;
      else $display("FAIL f1_valid_%0d: got %0h", k, out_valid1);
      n_total++;
      if (act1 === vecs1[k].exp) n_pass++;
      else $display("FAIL f1_act_%0d: got %0h expected %0h", k, act1, vecs1[k].exp);
      n_total++;
      if (fold1 === 1'b0) n_pass++;
      else $display("FAIL f1_fold_%0d: got %0h", k, fold1);
`ifdef FC_RAW_SUM_EN
      `CHK($sformatf("f1_sum_%0d", k), sum1, {7'(vecs1[k].pc[1]), 7'(vecs1[k].pc[0])});
`endif
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    `CHK("f1_idle_in_ready", in_ready1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fc_popcount_act.md
Name: fc_popcount_act

Overview:
- Consumer side of the XNOR product array in the binarized FC datapath.
- Takes one fold slice of XNOR products per beat: DIM_OUT/FOLD neurons × DIM_IN bits.
- For each neuron it computes the popcount, compares it with a per-neuron threshold, and packs the resulting binary activations into the full DIM_OUT vector over FOLD beats.
- Sits between the product array and the next layer or the output register.

Parameters:
- DIM_IN, 110, input vector width (bits per neuron).
- DIM_OUT, 4, total output neurons.
- FOLD, 2, number of beats per output vector. DIM_OUT % FOLD == 0 is required.
- SLICE (localparam), DIM_OUT/FOLD, neurons per beat.
- CNT_W (localparam), $clog2(DIM_IN+1), popcount width.
- FW (localparam), max(1,$clog2(FOLD)), fold counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  slice beat valid
- in_ready  out  1  block can accept a beat
- mult_out  in  [SLICE][DIM_IN]  XNOR products for the current slice
- thresh  in  [SLICE][CNT_W]  per-neuron threshold for the current slice, sampled with the beat
- out_valid  out  1  full activation vector available
- out_ready  in  1  downstream accepts the vector
- act_out  out  [DIM_OUT]  binary activations; bit j is neuron j
- fold_idx  out  FW  index of the slice expected next, so upstream can select weights and thresholds

Behaviour:
- One clock domain, clk. rst is synchronous, active-high.
- Reset values: state=ACCUM, fold_idx=0, act_out=0, out_valid=0, in_ready=1. Popcount sums = 0 (feature build only).
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Beat accepted when in_valid && in_ready. Each neuron s of the slice:
  - pc[s] = number of ones in mult_out[s], unsigned CNT_W bits, no overflow possible.
  - act = (pc[s] >= thresh[s]), unsigned compare.
  - The result is registered into act_out[fold_idx*SLICE + s] on that edge. Other act_out bits hold.
- fold_idx:
  - Increments on each accepted beat.
  - On an accepted beat with fold_idx==FOLD-1: fold_idx wraps to 0 and the state goes to DONE.
  - out_valid rises the cycle after the last beat. Latency from last beat to out_valid is 1 cycle.
- DONE:
  - act_out is held stable and in_valid is ignored.
  - On out_valid && out_ready: state returns to ACCUM. act_out is not cleared; the next beats overwrite it slice by slice.
- FOLD==1: every beat produces a complete vector. Maximum throughput is one vector per 2 cycles, because there is no bypass of DONE. This is intentional for timing.
- Thresholds: thresh = 0 forces act=1. thresh > DIM_IN forces act=0.
- Reset mid-fold: the partial vector is discarded, fold_idx returns to 0 and act_out clears.
- Reset while in DONE: the pending vector is dropped and out_valid deasserts the next cycle.
- in_valid deasserted mid-fold: the state and fold_idx hold indefinitely.
- X on mult_out while in_valid=0 must not propagate into any register.

Optional Feature:
- Macro: FC_RAW_SUM_EN (regression-layer output).
- Defined:
  - Adds output port sum_out [DIM_OUT][CNT_W].
  - sum_out[fold_idx*SLICE+s] registers pc[s] on each accepted beat, using the same timing, hold and reset rules as act_out.
  - The thresh port is still present and act_out is still produced.
- Undefined:
  - sum_out does not exist and no popcount registers are instantiated.

Decomposition:
- Shared package fc_pkg:
  - DIM_IN, DIM_OUT, FOLD defaults.
  - CNT_W, SLICE and FW derived as functions/localparams.
  - State enum typedef (ACCUM, DONE).
  - Typedef cnt_t = logic [CNT_W-1:0].
- One sub-module, fc_popcount: purely combinational, DIM_IN bits in, CNT_W count out. Instantiated SLICE times so it can be swapped for an adder tree or a pipelined variant.

Test Plan:
- Basic pass, all equal: FOLD=2, DIM_IN=110. Beat0 all-ones slice with thresh=55, then beat1 all-zeros with thresh=55 → act_out=4'b0011 one cycle after beat1, out_valid=1. sum_out={0,0,110,110} with FC_RAW_SUM_EN.
- Thresholds at the boundary, popcount=55 in every neuron:
  - thresh=55 → act bit 1.
  - thresh=56 → 0.
  - thresh=0 → 1.
  - thresh=111 → 0.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 held.
  - in_ready=0 throughout, act_out stable, no beat consumed.
  - Release → next beat is accepted as fold 0.
- Gaps: in_valid toggles 1,0,0,1 → fold_idx goes 0→1 and holds, vector completes only on the second accepted beat.
- Reset mid-fold: after beat0, assert rst for 1 cycle → fold_idx=0, act_out=0, out_valid stays 0. The next two beats produce a fresh correct vector.
- FOLD=1 build: back-to-back in_valid with out_ready=1 → in_ready pattern 1,0,1,0. One vector per 2 cycles, each matching its popcount/threshold reference model.
